// File: rtl/boot_rom_arb_pkg.sv
// boot_rom_arb_pkg: shared types and constants for the boot ROM arbiter.
// Holds the FSM state encoding and the grant encoding used to tag which
// requester (instruction fetch or data load) owns the current ROM access.
package boot_rom_arb_pkg;

  // Arbiter FSM states: one ROM access walks IDLE -> ADDR -> DATA -> RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  // Grant encoding: requester 0 is instruction fetch, requester 1 is data load.
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_LOAD  = 1'b1;

endpackage : boot_rom_arb_pkg

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: shares a single-port, 1-cycle-latency synchronous boot
// ROM between an instruction-fetch requester (0) and a data-load requester (1).
// Each access registers the ROM address, waits out the ROM latency, captures
// rom_q into the granted requester's rdata register and pulses its ready for
// exactly one cycle. One access completes every 4 cycles.
//
// Build option BOOT_ROM_ARB_RR_EN:
//   defined   - round-robin between the two requesters on contention
//   undefined - fixed priority, requester 0 (fetch) wins on contention
module boot_rom_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  busy
);

  state_e                r_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_ready0;
  logic                  r_ready1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_busy;

  logic                  w_any_valid;
  logic                  w_pick;

  // Grant selection for a new access, evaluated only while IDLE.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_pick      = GRANT_FETCH;
`ifdef BOOT_ROM_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      w_pick = ~r_last_grant;
    end else if (req1_valid) begin
      w_pick = GRANT_LOAD;
    end else begin
      w_pick = GRANT_FETCH;
    end
`else
    if (req0_valid) begin
      w_pick = GRANT_FETCH;
    end else if (req1_valid) begin
      w_pick = GRANT_LOAD;
    end else begin
      w_pick = GRANT_FETCH;
    end
`endif
  end

  // Access FSM with all outputs registered; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant      <= GRANT_FETCH;
      r_last_grant <= GRANT_LOAD;
      r_rom_addr   <= '0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_rom_addr <= (w_pick == GRANT_LOAD) ? req1_addr : req0_addr;
            r_grant    <= w_pick;
            r_busy     <= 1'b1;
            r_state    <= ADDR;
          end
        end
        ADDR: begin
          r_state <= DATA;
        end
        DATA: begin
          if (r_grant == GRANT_LOAD) begin
            r_rdata1 <= rom_q;
            r_ready1 <= 1'b1;
          end else begin
            r_rdata0 <= rom_q;
            r_ready0 <= 1'b1;
          end
          r_last_grant <= r_grant;
          r_state      <= RESP;
        end
        RESP: begin
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign busy       = r_busy;

  // Only one requester is ever answered at a time.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!resetn)
    !(r_ready0 && r_ready1));

  // The response cycle always belongs to the grant just recorded as last_grant.
  a_last_grant: assert property (@(posedge clk) disable iff (!resetn)
    (r_state == RESP) |-> (r_last_grant == r_grant));

endmodule : boot_rom_arbiter
